// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - instruction fetch stage: PC, ROM read issue, instruction queue, redirect flush
module cpu_fetch #(
    parameter int g_ROM_WIDTH = 11,
    parameter int g_ROM_ADDR  = 9,
    parameter int g_DEPTH     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic                   o_rom_en,
    output logic [g_ROM_ADDR-1:0]  o_rom_addr,
    input  logic [g_ROM_WIDTH-1:0] i_rom_data,
    input  logic                   i_halt,
    input  logic                   i_redirect,
    input  logic [g_ROM_ADDR-1:0]  i_redirect_addr,
    output logic                   o_instr_valid,
    output logic [g_ROM_WIDTH-1:0] o_instr,
    output logic [g_ROM_ADDR-1:0]  o_instr_pc,
    input  logic                   i_instr_ready
);

    localparam int PW = $clog2(g_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(g_DEPTH);
    localparam logic [CW-1:0]         CNT_ONE = 1;
    localparam logic [PW-1:0]         PTR_ONE = 1;
    localparam logic [g_ROM_ADDR-1:0] PC_ONE  = 1;

    logic [g_ROM_ADDR-1:0]  pc;
    logic [g_ROM_ADDR-1:0]  inflight_pc;
    logic                   inflight;
    logic [CW-1:0]          count;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [g_ROM_WIDTH-1:0] word_q [g_DEPTH];
    logic [g_ROM_ADDR-1:0]  pc_q   [g_DEPTH];

    logic [CW:0] occupancy;
    logic        credit;
    logic        issue;
    logic        wr_en;
    logic        rd_en;

    // Queued words plus the one in flight must never exceed the queue size,
    // so a returning word always has a free slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign credit    = occupancy < {1'b0, DEPTH_C};
    assign issue     = i_rst && !i_halt && !i_redirect && credit;
    assign wr_en     = inflight && !i_redirect;
    assign rd_en     = o_instr_valid && i_instr_ready && !i_redirect;

    assign o_rom_en      = issue;
    assign o_rom_addr    = pc;
    assign o_instr_valid = (count != '0);
    assign o_instr       = word_q[head];
    assign o_instr_pc    = pc_q[head];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (i_redirect) begin
            pc       <= i_redirect_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + PC_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < g_DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (i_redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                word_q[tail] <= i_rom_data;
                pc_q[tail]   <= inflight_pc;
                tail         <= tail + PTR_ONE;
            end
            if (rd_en) begin
                head <= head + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - directed self-checking bench for cpu_fetch
module tb_cpu_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        o_rom_en;
    logic [8:0]  o_rom_addr;
    logic [10:0] i_rom_data = '0;
    logic        i_halt = 1'b0;
    logic        i_redirect = 1'b0;
    logic [8:0]  i_redirect_addr = '0;
    logic        o_instr_valid;
    logic [10:0] o_instr;
    logic [8:0]  o_instr_pc;
    logic        i_instr_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    cpu_fetch #(.g_ROM_WIDTH(11), .g_ROM_ADDR(9), .g_DEPTH(4)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_rom_en       (o_rom_en),
        .o_rom_addr     (o_rom_addr),
        .i_rom_data     (i_rom_data),
        .i_halt         (i_halt),
        .i_redirect     (i_redirect),
        .i_redirect_addr(i_redirect_addr),
        .o_instr_valid  (o_instr_valid),
        .o_instr        (o_instr),
        .o_instr_pc     (o_instr_pc),
        .i_instr_ready  (i_instr_ready)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous ROM: ROM[a] = a + 0x100
    always @(posedge i_clk) begin
        if (o_rom_en) i_rom_data <= {2'b00, o_rom_addr} + 11'h100;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Leaves the bench at cycle 0 (posedge+1), reset just released
    task automatic apply_reset();
        i_rst = 1'b0;
        i_halt = 1'b0;
        i_redirect = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_instr_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (o_rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%0b exp=0", o_rom_en); end
        checks++; if (o_rom_addr !== 9'h000) begin failures++; $display("FAIL reset_rom_addr got=%0h exp=0", o_rom_addr); end
        checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_instr_valid); end
        checks++; if (o_instr !== 11'h000) begin failures++; $display("FAIL reset_instr got=%0h exp=0", o_instr); end
        checks++; if (o_instr_pc !== 9'h000) begin failures++; $display("FAIL reset_pc got=%0h exp=0", o_instr_pc); end
    endtask

    task automatic test_stream();
        apply_reset();
        i_instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (o_rom_en !== 1'b1 || o_rom_addr !== 9'(k)) begin failures++; $display("FAIL stream_issue c%0d got en=%0b addr=%0h exp en=1 addr=%0h", k, o_rom_en, o_rom_addr, k); end
            checks++; if (o_instr_valid !== (k >= 2)) begin failures++; $display("FAIL stream_valid c%0d got=%0b exp=%0b", k, o_instr_valid, (k >= 2)); end
            if (k >= 2) begin
                checks++; if (o_instr !== 11'(32'h100 + k - 2) || o_instr_pc !== 9'(k - 2)) begin failures++; $display("FAIL stream_word c%0d got instr=%0h pc=%0h exp instr=%0h pc=%0h", k, o_instr, o_instr_pc, 32'h100 + k - 2, k - 2); end
            end
            tick();
        end
    endtask

    task automatic test_full();
        apply_reset();
        i_instr_ready = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k == 6) i_instr_ready = 1'b1;
            #1;
            if (k < 4) begin
                checks++; if (o_rom_en !== 1'b1 || o_rom_addr !== 9'(k)) begin failures++; $display("FAIL full_issue c%0d got en=%0b addr=%0h exp en=1 addr=%0h", k, o_rom_en, o_rom_addr, k); end
            end else if (k < 7) begin
                checks++; if (o_rom_en !== 1'b0) begin failures++; $display("FAIL full_stall c%0d got en=%0b exp=0", k, o_rom_en); end
            end else begin
                checks++; if (o_rom_en !== 1'b1 || o_rom_addr !== 9'(k - 3)) begin failures++; $display("FAIL full_resume c%0d got en=%0b addr=%0h exp en=1 addr=%0h", k, o_rom_en, o_rom_addr, k - 3); end
            end
            if (k >= 6) begin
                checks++; if (o_instr_valid !== 1'b1 || o_instr !== 11'(32'h100 + k - 6) || o_instr_pc !== 9'(k - 6)) begin failures++; $display("FAIL full_drain c%0d got v=%0b instr=%0h pc=%0h exp v=1 instr=%0h pc=%0h", k, o_instr_valid, o_instr, o_instr_pc, 32'h100 + k - 6, k - 6); end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        i_instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        // cycle 4: three words queued, one read in flight
        i_redirect = 1'b1;
        i_redirect_addr = 9'h050;
        i_instr_ready = 1'b1;
        #1;
        checks++; if (o_rom_en !== 1'b0) begin failures++; $display("FAIL redir_en_R got=%0b exp=0", o_rom_en); end
        tick();
        i_redirect = 1'b0;
        #1;
        checks++; if (o_instr_valid !== 1'b0 || o_rom_en !== 1'b1 || o_rom_addr !== 9'h050) begin failures++; $display("FAIL redir_R1 got v=%0b en=%0b addr=%0h exp v=0 en=1 addr=50", o_instr_valid, o_rom_en, o_rom_addr); end
        tick();
        #1;
        checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL redir_R2_valid got=%0b exp=0", o_instr_valid); end
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (o_instr_valid !== 1'b1 || o_instr !== 11'(32'h150 + k) || o_instr_pc !== 9'(32'h050 + k)) begin failures++; $display("FAIL redir_word%0d got v=%0b instr=%0h pc=%0h exp v=1 instr=%0h pc=%0h", k, o_instr_valid, o_instr, o_instr_pc, 32'h150 + k, 32'h050 + k); end
            tick();
        end
    endtask

    task automatic test_wrap();
        i_instr_ready = 1'b1;
        i_redirect = 1'b1;
        i_redirect_addr = 9'h1FE;
        #1;
        checks++; if (o_rom_en !== 1'b0) begin failures++; $display("FAIL wrap_en_R got=%0b exp=0", o_rom_en); end
        tick();
        i_redirect = 1'b0;
        #1;
        checks++; if (o_rom_en !== 1'b1 || o_rom_addr !== 9'h1FE || o_instr_valid !== 1'b0) begin failures++; $display("FAIL wrap_R1 got en=%0b addr=%0h v=%0b exp en=1 addr=1fe v=0", o_rom_en, o_rom_addr, o_instr_valid); end
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 9'(32'h1FE + k) || o_instr !== 11'(32'h100 + ((32'h1FE + k) % 512))) begin failures++; $display("FAIL wrap_word%0d got v=%0b instr=%0h pc=%0h exp pc=%0h", k, o_instr_valid, o_instr, o_instr_pc, (32'h1FE + k) % 512); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        i_instr_ready = 1'b1;
        i_redirect = 1'b1;
        i_redirect_addr = 9'h010;
        tick();
        i_redirect_addr = 9'h020;
        #1;
        checks++; if (o_rom_en !== 1'b0 || o_instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_second got en=%0b v=%0b exp en=0 v=0", o_rom_en, o_instr_valid); end
        tick();
        i_redirect = 1'b0;
        #1;
        checks++; if (o_rom_en !== 1'b1 || o_rom_addr !== 9'h020) begin failures++; $display("FAIL b2b_target got en=%0b addr=%0h exp en=1 addr=20", o_rom_en, o_rom_addr); end
        tick();
        #1;
        checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%0b exp=0", o_instr_valid); end
        tick();
        #1;
        checks++; if (o_instr_valid !== 1'b1 || o_instr !== 11'h120 || o_instr_pc !== 9'h020) begin failures++; $display("FAIL b2b_word got v=%0b instr=%0h pc=%0h exp v=1 instr=120 pc=20", o_instr_valid, o_instr, o_instr_pc); end
        tick();
    endtask

    task automatic test_halt();
        apply_reset();
        i_instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        // cycle 5: head pc 3, addr 4 in flight
        i_halt = 1'b1;
        #1;
        checks++; if (o_rom_en !== 1'b0 || o_instr_pc !== 9'h003 || o_instr_valid !== 1'b1) begin failures++; $display("FAIL halt_c5 got en=%0b v=%0b pc=%0h exp en=0 v=1 pc=3", o_rom_en, o_instr_valid, o_instr_pc); end
        tick();
        #1;
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 9'h004 || o_instr !== 11'h104) begin failures++; $display("FAIL halt_inflight got v=%0b instr=%0h pc=%0h exp v=1 instr=104 pc=4", o_instr_valid, o_instr, o_instr_pc); end
        tick();
        #1;
        checks++; if (o_instr_valid !== 1'b0 || o_rom_en !== 1'b0 || o_rom_addr !== 9'h005) begin failures++; $display("FAIL halt_drained got v=%0b en=%0b addr=%0h exp v=0 en=0 addr=5", o_instr_valid, o_rom_en, o_rom_addr); end
        tick();
        i_halt = 1'b0;
        #1;
        checks++; if (o_rom_en !== 1'b1 || o_rom_addr !== 9'h005) begin failures++; $display("FAIL halt_resume got en=%0b addr=%0h exp en=1 addr=5", o_rom_en, o_rom_addr); end
        tick();
        #1;
        checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL halt_gap got=%0b exp=0", o_instr_valid); end
        tick();
        #1;
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 9'h005 || o_instr !== 11'h105) begin failures++; $display("FAIL halt_next got v=%0b instr=%0h pc=%0h exp v=1 instr=105 pc=5", o_instr_valid, o_instr, o_instr_pc); end
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        i_instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #1;
        i_rst = 1'b0;
        #1;
        checks++; if (o_rom_en !== 1'b0 || o_rom_addr !== 9'h000 || o_instr_valid !== 1'b0 || o_instr !== 11'h000 || o_instr_pc !== 9'h000) begin failures++; $display("FAIL arst_outputs got en=%0b addr=%0h v=%0b instr=%0h pc=%0h exp all 0", o_rom_en, o_rom_addr, o_instr_valid, o_instr, o_instr_pc); end
        #1;
        i_rst = 1'b1;
        i_instr_ready = 1'b1;
        #1;
        checks++; if (o_rom_en !== 1'b1 || o_rom_addr !== 9'h000 || o_instr_valid !== 1'b0) begin failures++; $display("FAIL arst_restart got en=%0b addr=%0h v=%0b exp en=1 addr=0 v=0", o_rom_en, o_rom_addr, o_instr_valid); end
        tick();
        #1;
        checks++; if (o_rom_addr !== 9'h001 || o_instr_valid !== 1'b0) begin failures++; $display("FAIL arst_c1 got addr=%0h v=%0b exp addr=1 v=0", o_rom_addr, o_instr_valid); end
        tick();
        #1;
        checks++; if (o_instr_valid !== 1'b1 || o_instr !== 11'h100 || o_instr_pc !== 9'h000) begin failures++; $display("FAIL arst_first got v=%0b instr=%0h pc=%0h exp v=1 instr=100 pc=0", o_instr_valid, o_instr, o_instr_pc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
